// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: machine word and architectural register select.
// Default register-file geometry is derived from these.
package cpu_types_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned NREG_DEF = 32;

  typedef logic [XLEN-1:0]              word_t;
  typedef logic [$clog2(NREG_DEF)-1:0]  regsel_t;

endpackage

// File: rtl/regfile_bypass.sv
// Per-read-port write-through select: the highest-index write port targeting the
// selected register overrides the stored value; register 0 always reads zero.
module regfile_bypass #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned SW     = 5,
  parameter int unsigned NWR    = 2
) (
  input  logic [SW-1:0]         rsel_i,
  input  logic [DATA_W-1:0]     stored_i,
  input  logic [NWR-1:0]        wen_i,
  input  logic [NWR*SW-1:0]     wsel_i,
  input  logic [NWR*DATA_W-1:0] wdat_i,
  output logic [DATA_W-1:0]     rdat_o
);

  always_comb begin
    rdat_o = stored_i;
    for (int unsigned i = 0; i < NWR; i++) begin
      if (wen_i[i] && (wsel_i[i*SW +: SW] == rsel_i)) begin
        rdat_o = wdat_i[i*DATA_W +: DATA_W];
      end
    end
    if (rsel_i == '0) begin
      rdat_o = '0;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-ported register file with write-through reads and a pending-write
// scoreboard (per-register busy bits plus a registered population count).
module regfile_mp
  import cpu_types_pkg::*;
#(
  parameter int unsigned DATA_W = $bits(word_t),
  parameter int unsigned NREG   = NREG_DEF,
  parameter int unsigned NRD    = 2,
  parameter int unsigned NWR    = 2,
  localparam int unsigned SW    = $clog2(NREG),
  localparam int unsigned CW    = SW + 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [NRD*SW-1:0]     rsel,
  output logic [NRD*DATA_W-1:0] rdat,
  output logic [NRD-1:0]        rbusy,
  input  logic [NWR-1:0]        wen,
  input  logic [NWR*SW-1:0]     wsel,
  input  logic [NWR*DATA_W-1:0] wdat,
  input  logic                  ren,
  input  logic [SW-1:0]         rsv_sel,
  output logic [CW-1:0]         pend_cnt
);

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];
  logic [NREG-1:0]   pend_q, pend_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [CW-1:0]     inc, dec;

  always_comb begin
    regs_d = regs_q;
    pend_d = pend_q;
    inc    = '0;
    dec    = '0;
    // Later ports overwrite earlier ones, giving highest-index priority.
    for (int unsigned i = 0; i < NWR; i++) begin
      if (wen[i] && (wsel[i*SW +: SW] != '0)) begin
        regs_d[wsel[i*SW +: SW]] = wdat[i*DATA_W +: DATA_W];
        pend_d[wsel[i*SW +: SW]] = 1'b0;
      end
    end
    // Reserve applied after clears so a same-register set wins.
    if (ren && (rsv_sel != '0)) begin
      pend_d[rsv_sel] = 1'b1;
    end
    // Net count change from per-bit transitions; duplicate clears count once.
    for (int unsigned r = 1; r < NREG; r++) begin
      if (pend_d[r] && !pend_q[r]) inc = inc + CW'(1);
      if (!pend_d[r] && pend_q[r]) dec = dec + CW'(1);
    end
    cnt_d = cnt_q + inc - dec;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      regs_q <= '{default: '0};
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      regs_q <= regs_d;
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  assign pend_cnt = cnt_q;

  for (genvar j = 0; j < NRD; j++) begin : g_rd
    regfile_bypass #(
      .DATA_W (DATA_W),
      .SW     (SW),
      .NWR    (NWR)
    ) u_byp (
      .rsel_i   (rsel[j*SW +: SW]),
      .stored_i (regs_q[rsel[j*SW +: SW]]),
      .wen_i    (wen),
      .wsel_i   (wsel),
      .wdat_i   (wdat),
      .rdat_o   (rdat[j*DATA_W +: DATA_W])
    );
    assign rbusy[j] = pend_q[rsel[j*SW +: SW]];
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: directed scenarios then randomized traffic, all checked
// against an array-based reference of register contents and pending flags.
module tb_regfile_mp;
  import cpu_types_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned NR = 32;

  logic          CLK = 1'b0;
  logic          RST;
  logic [9:0]    rsel;
  logic [63:0]   rdat;
  logic [1:0]    rbusy;
  logic [1:0]    wen;
  logic [9:0]    wsel;
  logic [63:0]   wdat;
  logic          ren;
  logic [4:0]    rsv_sel;
  logic [5:0]    pend_cnt;

  regfile_mp #(
    .DATA_W (DW),
    .NREG   (NR),
    .NRD    (2),
    .NWR    (2)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .rsel     (rsel),
    .rdat     (rdat),
    .rbusy    (rbusy),
    .wen      (wen),
    .wsel     (wsel),
    .wdat     (wdat),
    .ren      (ren),
    .rsv_sel  (rsv_sel),
    .pend_cnt (pend_cnt)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Reference state
  word_t m_reg  [NR];
  bit    m_pend [NR];

  // Values seen during the most recent step (for directed expectations)
  word_t     o_rd0, o_rd1;
  logic      o_bz0, o_bz1;
  logic [5:0] o_cnt;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic word_t m_read(input regsel_t s, input logic [1:0] we,
                                   input regsel_t ws0, input regsel_t ws1,
                                   input word_t wd0, input word_t wd1);
    word_t v;
    if (s == 0) return '0;
    v = m_reg[s];
    if (we[0] && ws0 == s) v = wd0;
    if (we[1] && ws1 == s) v = wd1;
    return v;
  endfunction

  function automatic int m_count();
    int n = 0;
    for (int r = 0; r < NR; r++) n += int'(m_pend[r]);
    return n;
  endfunction

  // One clock cycle: drive, check combinational outputs against the model, clock, update model.
  task automatic step(input bit do_chk, input logic r, input logic [1:0] we,
                      input regsel_t ws0, input regsel_t ws1, input word_t wd0, input word_t wd1,
                      input logic re, input regsel_t rs, input regsel_t rd0, input regsel_t rd1);
    @(negedge CLK);
    RST = r; wen = we; wsel = {ws1, ws0}; wdat = {wd1, wd0};
    ren = re; rsv_sel = rs; rsel = {rd1, rd0};
    #1;
    o_rd0 = rdat[31:0]; o_rd1 = rdat[63:32];
    o_bz0 = rbusy[0];   o_bz1 = rbusy[1];
    o_cnt = pend_cnt;
    if (do_chk) begin
      check("rdat0", o_rd0, m_read(rd0, we, ws0, ws1, wd0, wd1));
      check("rdat1", o_rd1, m_read(rd1, we, ws0, ws1, wd0, wd1));
      check("rbusy0", o_bz0, m_pend[rd0]);
      check("rbusy1", o_bz1, m_pend[rd1]);
      check("pend_cnt", o_cnt, m_count());
    end
    @(posedge CLK);
    if (r) begin
      for (int k = 0; k < NR; k++) begin m_reg[k] = '0; m_pend[k] = 1'b0; end
    end else begin
      if (we[0] && ws0 != 0) begin m_reg[ws0] = wd0; m_pend[ws0] = 1'b0; end
      if (we[1] && ws1 != 0) begin m_reg[ws1] = wd1; m_pend[ws1] = 1'b0; end
      if (re && rs != 0) m_pend[rs] = 1'b1;
    end
  endtask

  task automatic idle(input regsel_t rd0, input regsel_t rd1);
    step(1'b1, 1'b0, 2'b00, 5'd0, 5'd0, '0, '0, 1'b0, 5'd0, rd0, rd1);
  endtask

  initial begin
    regsel_t ws0, ws1, rs, rd0, rd1;
    logic [1:0] we;
    logic re, rr;

    for (int k = 0; k < NR; k++) begin m_reg[k] = '0; m_pend[k] = 1'b0; end

    // Reset, then read r5
    step(1'b0, 1'b1, 2'b00, 5'd0, 5'd0, '0, '0, 1'b0, 5'd0, 5'd5, 5'd5);
    idle(5'd5, 5'd5);
    check("rst_rdat", o_rd0, 0);
    check("rst_rbusy", o_bz0, 0);
    check("rst_cnt", o_cnt, 0);

    // Write-through on port 0 seen by read port 1
    step(1'b1, 1'b0, 2'b01, 5'd3, 5'd0, 32'hDEADBEEF, '0, 1'b0, 5'd0, 5'd0, 5'd3);
    check("wt_same", o_rd1, 32'hDEADBEEF);
    idle(5'd0, 5'd3);
    check("wt_after", o_rd1, 32'hDEADBEEF);

    // Both ports write r7: port 1 wins
    step(1'b1, 1'b0, 2'b11, 5'd7, 5'd7, 32'h11, 32'h22, 1'b0, 5'd0, 5'd7, 5'd0);
    check("conf_same", o_rd0, 32'h22);
    idle(5'd7, 5'd7);
    check("conf_after", o_rd1, 32'h22);

    // r0 protection
    step(1'b1, 1'b0, 2'b01, 5'd0, 5'd0, 32'hFFFF, '0, 1'b1, 5'd0, 5'd0, 5'd0);
    check("r0_rdat_same", o_rd0, 0);
    idle(5'd0, 5'd0);
    check("r0_rdat", o_rd0, 0);
    check("r0_rbusy", o_bz0, 0);
    check("r0_cnt", o_cnt, 0);

    // Scoreboard: reserve r4, then reserve r9 with write to r4
    step(1'b1, 1'b0, 2'b00, 5'd0, 5'd0, '0, '0, 1'b1, 5'd4, 5'd4, 5'd9);
    step(1'b1, 1'b0, 2'b01, 5'd4, 5'd0, 32'h44, '0, 1'b1, 5'd9, 5'd4, 5'd9);
    check("sb_cnt1", o_cnt, 1);
    check("sb_busy4_pre", o_bz0, 1);
    idle(5'd4, 5'd9);
    check("sb_cnt2", o_cnt, 1);
    check("sb_busy4", o_bz0, 0);
    check("sb_busy9", o_bz1, 1);

    // Set wins over clear on r6
    step(1'b1, 1'b0, 2'b01, 5'd6, 5'd0, 32'hA5A5A5A5, '0, 1'b1, 5'd6, 5'd6, 5'd9);
    idle(5'd6, 5'd9);
    check("sw_rdat", o_rd0, 32'hA5A5A5A5);
    check("sw_busy", o_bz0, 1);
    check("sw_cnt", o_cnt, 2);

    // Reset mid-stream with a write and a reservation in flight
    step(1'b1, 1'b1, 2'b11, 5'd6, 5'd12, 32'h1234, 32'h5678, 1'b1, 5'd10, 5'd6, 5'd12);
    idle(5'd6, 5'd10);
    check("mrst_cnt", o_cnt, 0);
    for (int k = 0; k < NR; k += 2) begin
      idle(regsel_t'(k), regsel_t'(k + 1));
      check("mrst_rd0", o_rd0, 0);
      check("mrst_rd1", o_rd1, 0);
      check("mrst_bz0", o_bz0, 0);
      check("mrst_bz1", o_bz1, 0);
    end

    // Randomized traffic; a narrow select range is mixed in to force collisions
    for (int n = 0; n < 3000; n++) begin
      rr  = ($urandom_range(0, 99) == 0);
      we  = {($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0)};
      re  = ($urandom_range(0, 3) != 0);
      ws0 = ($urandom_range(0, 1) != 0) ? regsel_t'($urandom_range(0, 7)) : regsel_t'($urandom_range(0, NR - 1));
      ws1 = ($urandom_range(0, 1) != 0) ? regsel_t'($urandom_range(0, 7)) : regsel_t'($urandom_range(0, NR - 1));
      rs  = ($urandom_range(0, 1) != 0) ? regsel_t'($urandom_range(0, 7)) : regsel_t'($urandom_range(0, NR - 1));
      rd0 = ($urandom_range(0, 1) != 0) ? regsel_t'($urandom_range(0, 7)) : regsel_t'($urandom_range(0, NR - 1));
      rd1 = regsel_t'($urandom_range(0, NR - 1));
      step(1'b1, rr, we, ws0, ws1, $urandom, $urandom, re, rs, rd0, rd1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter DATA_W, default 32: register width in bits.
REQ-002 SHALL have parameter NREG, default 32: register count, a power of two and at least 2.
REQ-003 SHALL have parameter NRD, default 2: number of read ports.
REQ-004 SHALL have parameter NWR, default 2: number of write ports.
REQ-005 SHALL use one clock and a reset that is synchronous and active-high.
REQ-006 SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-007 SHALL have port RST, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have port rsel, input, NRD x log2(NREG) bits: read register selects.
REQ-009 SHALL have port rdat, output, NRD x DATA_W bits: read data.
REQ-010 SHALL have port rbusy, output, NRD bits: the selected register has a pending write.
REQ-011 SHALL have port wen, input, NWR bits: write enables.
REQ-012 SHALL have port wsel, input, NWR x log2(NREG) bits: write register selects.
REQ-013 SHALL have port wdat, input, NWR x DATA_W bits: write data.
REQ-014 SHALL have port ren, input, 1 bit: reserve (issue) enable.
REQ-015 SHALL have port rsv_sel, input, log2(NREG) bits: register to mark as pending.
REQ-016 SHALL have port pend_cnt, output, log2(NREG)+1 bits: number of pending registers.

Function
REQ-017 SHALL update the registers on the rising edge of CLK: each port with wen[i] and wsel[i]!=0 writes wdat[i].
REQ-018 SHALL keep register 0 at zero: writes to it are discarded, it is never pending, and reads of it return 0 with rbusy=0.
REQ-019 SHALL resolve same-cycle writes to the same register by letting the highest-index port win.
REQ-020 SHALL compute rdat combinationally, with write-through: if a port is writing rsel[j] this cycle, rdat[j] is that port's wdat (highest index wins), otherwise the stored value.
REQ-021 SHALL hold a pending bit per register: ren with rsv_sel!=0 sets it at the next edge.
REQ-022 SHALL clear a register's pending bit at the next edge when any enabled write port targets that register.
REQ-023 SHALL let set win when a reserve and a write hit the same register in the same cycle: the data is written and the bit stays pending.
REQ-024 SHALL make rbusy[j] the registered pending bit of rsel[j], without bypass: it goes 0 only on the cycle after the clearing write.
REQ-025 SHALL make pend_cnt a registered count that always equals the population of the pending bits.
REQ-026 SHALL change pend_cnt by +1, -1 or net per cycle, so that a set with several clears in one edge is exact.
REQ-027 SHALL leave pend_cnt unchanged when a reserve targets a register that is already pending.
REQ-028 SHALL treat a write to a register that is not pending as a normal write, with no counter underflow.
REQ-029 SHALL let pend_cnt reach NREG-1 at most, with no wrap.

Reset
REQ-030 SHALL, on RST high at a rising edge, zero all registers, clear all pending bits and set pend_cnt=0.
REQ-031 SHALL give reset priority over writes and reserves in that cycle.
REQ-032 SHALL produce rdat=0 and rbusy=0 for any rsel after reset, before any write.
REQ-033 SHALL discard any write or reservation that is in flight when a mid-operation reset occurs.

Structure
REQ-034 SHALL take default widths and the regsel_t/word_t typedefs from cpu_types_pkg.
REQ-035 SHALL place the bypass/priority select in one sub-module, regfile_bypass (per read port: priority mux over write ports).
REQ-036 SHALL drive pending-bit and counter logic from one always_ff with a separate next-state always_comb.

Verification
REQ-037 SHALL cover reset then read: RST=1 for 1 cycle, read r5 -> rdat=0, rbusy=0, pend_cnt=0.
REQ-038 SHALL cover write-through: wen[0], wsel=3, wdat=0xDEADBEEF, rsel[1]=3 in the same cycle -> rdat[1]=0xDEADBEEF that cycle and after.
REQ-039 SHALL cover port conflict: ports 0 and 1 write r7 with 0x11 and 0x22 -> r7 reads 0x22.
REQ-040 SHALL cover r0 protection: write r0=0xFFFF and reserve r0 -> rdat=0, rbusy=0, pend_cnt=0.
REQ-041 SHALL cover the scoreboard: reserve r4, then next cycle reserve r9 plus write r4 -> pend_cnt 1 then 1; rbusy(r4)=0, rbusy(r9)=1.
REQ-042 SHALL cover set-wins and reset: reserve and write r6 in the same cycle -> r6 updated, still pending; then RST mid-stream -> pend_cnt=0 and all registers 0.
